// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for alu_pipe.
// ALU_MUL_EN adds the MUL state to the S1 control FSM.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  localparam int unsigned F_Z   = 0;
  localparam int unsigned F_N   = 1;
  localparam int unsigned F_C   = 2;
  localparam int unsigned F_V   = 3;
  localparam int unsigned F_ILL = 4;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_MUL = 2'd2} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;
`endif

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, W cycles.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           ck,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  // done marks the cycle whose edge performs the final iteration
  assign done = busy && (cnt == LAST);
  assign prod = acc;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{W{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with Z,N,C,V,ILL flags.
// ALU_MUL_EN enables opcode 0010 (MUL) via the alu_mul_seq iterative multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output logic [4:0]   flags
);

  state_t       state, state_nxt;
  logic         rdy_en;
  logic [3:0]   s1_op;
  logic [W-1:0] s1_a, s1_b;
  logic         res_rdy, s1_move, accept, new_mul;
  logic [W-1:0] res_o;
  logic [4:0]   res_f;
  logic         c, v, ill;
  logic [W:0]   sum, diff;

`ifdef ALU_MUL_EN
  logic           mul_busy, mul_done;
  logic [2*W-1:0] mul_prod;

  alu_mul_seq #(.W(W)) u_mul (
    .ck    (ck),
    .rst_n (rst_n),
    .start (accept && new_mul),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign new_mul  = (op == OP_MUL);
  assign in_ready = rdy_en && !mul_busy && ((state == ST_IDLE) || s1_move);
`else
  assign new_mul  = 1'b0;
  assign in_ready = rdy_en && ((state == ST_IDLE) || s1_move);
`endif

  // EXEC means S1 holds a finished result (a MUL reaches EXEC only once done)
  assign res_rdy = (state == ST_EXEC);
  assign s1_move = res_rdy && (!out_valid || out_ready);
  assign accept  = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = new_mul ? state_t'(2) : ST_EXEC;
      ST_EXEC: if (s1_move) begin
        if (accept) state_nxt = new_mul ? state_t'(2) : ST_EXEC;
        else        state_nxt = ST_IDLE;
      end
`ifdef ALU_MUL_EN
      ST_MUL:  if (mul_done) state_nxt = ST_EXEC;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff = {1'b0, s1_a} - {1'b0, s1_b};

  always_comb begin
    res_o = '0;
    c     = 1'b0;
    v     = 1'b0;
    ill   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_o = sum[W-1:0];
        c     = sum[W];
        v     = (s1_a[W-1] == s1_b[W-1]) && (sum[W-1] != s1_a[W-1]);
      end
      OP_SUB: begin
        res_o = diff[W-1:0];
        c     = diff[W];
        v     = (s1_a[W-1] != s1_b[W-1]) && (diff[W-1] != s1_a[W-1]);
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        res_o = mul_prod[W-1:0];
        c     = |mul_prod[2*W-1:W];
      end
`endif
      OP_AND: res_o = s1_a & s1_b;
      OP_OR:  res_o = s1_a | s1_b;
      OP_XOR: res_o = s1_a ^ s1_b;
      OP_NOT: res_o = ~s1_a;
      OP_SRL: begin res_o = {1'b0, s1_a[W-1:1]};      c = s1_a[0];   end
      OP_SLL: begin res_o = {s1_a[W-2:0], 1'b0};      c = s1_a[W-1]; end
      OP_ROR: begin res_o = {s1_a[0], s1_a[W-1:1]};   c = s1_a[0];   end
      OP_ROL: begin res_o = {s1_a[W-2:0], s1_a[W-1]}; c = s1_a[W-1]; end
      default: ill = 1'b1;
    endcase
    res_f        = '0;
    res_f[F_Z]   = (res_o == '0);
    res_f[F_N]   = res_o[W-1];
    res_f[F_C]   = c;
    res_f[F_V]   = v;
    res_f[F_ILL] = ill;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rdy_en    <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      o         <= '0;
      flags     <= '0;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_nxt;
      if (accept) begin
        s1_op <= op;
        s1_a  <= a;
        s1_b  <= b;
      end
      if (s1_move) begin
        out_valid <= 1'b1;
        o         <= res_o;
        flags     <= res_f;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (W=8): vector table, scoreboard, stall/reset/MUL sequences.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] o;
  logic [4:0]   flags;

  alu_pipe #(.W(W)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .flags     (flags)
  );

  always #5 ck = ~ck;

  int tests = 0;
  int fails = 0;
  logic [12:0] sb_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model in integer arithmetic; returns {flags, o}
  function automatic logic [12:0] ref_alu(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int r = 0;
    int s = 0;
    bit c = 0, v = 0, ill = 0;
    logic [7:0] ro;
    case (f)
      4'h0: begin r = ux + uy; c = (r > 255); s = sx + sy; v = (s > 127) || (s < -128); end
      4'h1: begin r = ux - uy; c = (ux < uy); s = sx - sy; v = (s > 127) || (s < -128); end
`ifdef ALU_MUL_EN
      4'h2: begin r = ux * uy; c = (r > 255); end
`endif
      4'h8: r = ux & uy;
      4'h9: r = ux | uy;
      4'hA: r = ux ^ uy;
      4'hB: r = 255 - ux;
      4'hC: begin r = ux / 2; c = (ux % 2) == 1; end
      4'hD: begin r = ux * 2; c = (ux >= 128); end
      4'hE: begin r = ux / 2 + (ux % 2) * 128; c = (ux % 2) == 1; end
      4'hF: begin r = ux * 2 + ux / 128; c = (ux >= 128); end
      default: ill = 1;
    endcase
    ro = r[7:0];
    return {ill, v, c, ro[7], (ro == 8'h00), ro};
  endfunction

  always @(negedge ck) begin
    logic [12:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got o=%0h flags=%b expected no output", o, flags);
      end else begin
        e = sb_q.pop_front();
        chk("result", {flags, o}, e);
      end
    end
  end

  task automatic send(input logic [3:0] f_op, input logic [7:0] fa, input logic [7:0] fb, input logic [12:0] exp);
    int n = 0;
    in_valid = 1'b1;
    op = f_op;
    a = fa;
    b = fb;
    @(negedge ck);
    while (!in_ready && n < 200) begin
      @(negedge ck);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end else begin
      sb_q.push_back(exp);
    end
    @(posedge ck);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge ck);
      n++;
    end
    #1 chk("drain_empty", sb_q.size(), 0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic [4:0] ef;
  } vec_t;

  vec_t vt[15];
  logic [3:0] ops_l[12];
  logic [3:0] r_op;
  logic [7:0] ra, rb;
  bit rnd_done;

  initial begin
    // flags column is {ILL,V,C,N,Z}
    vt[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 5'b00101};
    vt[1]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 5'b01000};
    vt[2]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 5'b00110};
    vt[3]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b01010};
    vt[4]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 5'b00000};
    vt[5]  = '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 5'b00010};
    vt[6]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 5'b00001};
    vt[7]  = '{OP_NOT, 8'h0F, 8'h55, 8'hF0, 5'b00010};
    vt[8]  = '{OP_SRL, 8'h01, 8'h55, 8'h00, 5'b00101};
    vt[9]  = '{OP_SLL, 8'h81, 8'h55, 8'h02, 5'b00100};
    vt[10] = '{OP_ROR, 8'h01, 8'h55, 8'h80, 5'b00110};
    vt[11] = '{OP_ROL, 8'h81, 8'h55, 8'h03, 5'b00100};
    vt[12] = '{4'b0100, 8'h12, 8'h34, 8'h00, 5'b10001};
`ifdef ALU_MUL_EN
    vt[13] = '{OP_MUL, 8'h10, 8'h20, 8'h00, 5'b00101};
`else
    vt[13] = '{OP_MUL, 8'h10, 8'h20, 8'h00, 5'b10001};
`endif
    vt[14] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 5'b00001};
    ops_l = '{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SRL, OP_SLL, OP_ROR, OP_ROL, 4'b0111};

    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_o", o, 0);
    chk("rst_flags", flags, 0);
    repeat (2) @(posedge ck);
    #1 chk("rst_hold_in_ready", in_ready, 0);
    @(negedge ck) rst_n = 1'b1;
    @(posedge ck);
    #1 chk("post_rst_in_ready", in_ready, 1);

    // ADD latency: out_valid rises after the edge following acceptance
    send(OP_ADD, 8'hFF, 8'h01, {5'b00101, 8'h00});
    chk("lat_accept_edge", out_valid, 0);
    @(posedge ck);
    #1 chk("lat_next_edge", out_valid, 1);
    drain();

    for (int i = 0; i < 15; i++) send(vt[i].op, vt[i].a, vt[i].b, {vt[i].ef, vt[i].eo});
    drain();

    // Backpressure: two accepts fill S2 and S1, then in_ready drops and o holds
    out_ready = 1'b0;
    fork
      begin
        send(OP_ADD, 8'h12, 8'h34, ref_alu(OP_ADD, 8'h12, 8'h34));
        send(OP_SUB, 8'h20, 8'h50, ref_alu(OP_SUB, 8'h20, 8'h50));
        send(OP_XOR, 8'h5A, 8'hFF, ref_alu(OP_XOR, 8'h5A, 8'hFF));
        send(OP_ROR, 8'h03, 8'h00, ref_alu(OP_ROR, 8'h03, 8'h00));
      end
      begin
        repeat (3) @(posedge ck);
        #1 chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        repeat (2) begin
          @(posedge ck);
          #1 chk("bp_hold", {flags, o}, ref_alu(OP_ADD, 8'h12, 8'h34));
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef ALU_MUL_EN
    send(OP_MUL, 8'h10, 8'h20, {5'b00101, 8'h00});
    for (int k = 0; k < W; k++) begin
      chk("mul_in_ready_low", in_ready, 0);
      chk("mul_no_out", out_valid, 0);
      @(posedge ck);
      #1;
    end
    chk("mul_no_out_w", out_valid, 0);
    @(posedge ck);
    #1 chk("mul_out_w1", out_valid, 1);
    drain();
`endif

    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          r_op = ops_l[$urandom_range(0, 11)];
          ra = 8'($urandom);
          rb = 8'($urandom);
          send(r_op, ra, rb, ref_alu(r_op, ra, rb));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge ck);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with results pending in both stages
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, ref_alu(OP_ADD, 8'h01, 8'h02));
    send(OP_OR, 8'h80, 8'h01, ref_alu(OP_OR, 8'h80, 8'h01));
    #2 rst_n = 1'b0;
    #1 chk("midrst_out_valid", out_valid, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_in_ready", in_ready, 0);
    sb_q.delete();
    @(negedge ck) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge ck);
    #1 send(OP_SUB, 8'h00, 8'h01, {5'b00110, 8'hFF});
    drain();

`ifdef ALU_MUL_EN
    send(OP_MUL, 8'hFF, 8'hFF, ref_alu(OP_MUL, 8'hFF, 8'hFF));
    repeat (3) @(posedge ck);
    #3 rst_n = 1'b0;
    #1 chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_flags", flags, 0);
    sb_q.delete();
    @(negedge ck) rst_n = 1'b1;
    @(posedge ck);
    #1 send(OP_ADD, 8'h7F, 8'h01, {5'b01010, 8'h80});
    drain();
    repeat (12) @(posedge ck);
    #1 chk("mulrst_no_late_out", out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
